// File: rtl/temporizador_prog_pkg.sv
// temporizador_prog_pkg: shared state encoding and clock constants for the lift timer
package temporizador_prog_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} state_t;
  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DEF_PRESC_DIV = CLK_FREQ_HZ / 1000;
endpackage

// File: rtl/temporizador_prog_divisor_tick.sv
// temporizador_prog_divisor_tick: prescaler emitting one tick every PRESC_DIV enabled cycles
module temporizador_prog_divisor_tick #(
  parameter int PRESC_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick = en && (cnt_q == W'(PRESC_DIV - 1));
  always_ff @(posedge clk)
    cnt_q <= (rst || clr || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
endmodule

// File: rtl/temporizador_prog.sv
// temporizador_prog: programmable one-shot/periodic timer with pause, abort and restart
module temporizador_prog
  import temporizador_prog_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PRESC_DIV = DEF_PRESC_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodico,
  input  logic [WIDTH-1:0] periodo,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expirado
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, per_q, per_d;
  logic             mode_q, mode_d, busy_q, done_q, done_d, exp_q, exp_d, tick;
  temporizador_prog_divisor_tick #(.PRESC_DIV(PRESC_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (start || stop),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    per_d   = per_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    exp_d   = exp_q;
    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
      exp_d   = 1'b0;
    end else if (start) begin
      per_d   = periodo;
      mode_d  = periodico;
      count_d = '0;
      done_d  = (periodo == '0);
      exp_d   = (periodo == '0) && !periodico;
      state_d = (periodo != '0) ? ST_RUN : periodico ? ST_IDLE : ST_DONE;
    end else if (state_q == ST_RUN) begin
      if (tick && count_q == per_q - WIDTH'(1)) begin
        done_d  = 1'b1;
        count_d = mode_q ? '0 : per_q;
        exp_d   = !mode_q;
        state_d = mode_q ? ST_RUN : ST_DONE;
      end else if (tick) begin
        count_d = count_q + WIDTH'(1);
      end
      if (pause && state_d == ST_RUN)
        state_d = ST_PAUSE;
    end else if (state_q == ST_PAUSE && !pause) begin
      state_d = ST_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
      done_q  <= done_d;
      exp_q   <= exp_d;
    end
  end
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign expirado = exp_q;
endmodule

// File: tb/tb_temporizador_prog.sv
// tb_temporizador_prog: directed self-checking bench for the programmable timer
module tb_temporizador_prog;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start_b = 1'b0, stop = 1'b0, pause = 1'b0, periodico = 1'b0;
  logic [7:0] periodo = '0;
  logic [7:0] count, count_b;
  logic       busy, done, expirado, busy_b, done_b, expirado_b;
  int         tests = 0;
  int         fails = 0;
  temporizador_prog #(.WIDTH(8), .PRESC_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .periodico(periodico), .periodo(periodo),
    .count(count), .busy(busy), .done(done), .expirado(expirado)
  );
  temporizador_prog #(.WIDTH(8), .PRESC_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop), .pause(pause),
    .periodico(periodico), .periodo(periodo),
    .count(count_b), .busy(busy_b), .done(done_b), .expirado(expirado_b)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] p, input logic per);
    periodo = p;
    periodico = per;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask
  initial begin
    step(3);
    rst = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_exp", expirado, 0);
    go(8'd3, 1'b0);
    chk("os_busy_e0", busy, 1);
    chk("os_count_e0", count, 0);
    step(3);
    chk("os_count_e3", count, 0);
    step(1);
    chk("os_count_e4", count, 1);
    step(4);
    chk("os_count_e8", count, 2);
    step(3);
    chk("os_done_e11", done, 0);
    chk("os_busy_e11", busy, 1);
    step(1);
    chk("os_count_e12", count, 3);
    chk("os_done_e12", done, 1);
    chk("os_exp_e12", expirado, 1);
    chk("os_busy_e12", busy, 0);
    step(1);
    chk("os_done_e13", done, 0);
    chk("os_hold_e13", count, 3);
    chk("os_exp_e13", expirado, 1);
    go(8'd2, 1'b1);
    chk("per_exp_cleared", expirado, 0);
    step(4);
    chk("per_count_e4", count, 1);
    chk("per_done_e4", done, 0);
    step(4);
    chk("per_count_e8", count, 0);
    chk("per_done_e8", done, 1);
    chk("per_busy_e8", busy, 1);
    step(1);
    chk("per_done_e9", done, 0);
    step(3);
    chk("per_count_e12", count, 1);
    step(4);
    chk("per_count_e16", count, 0);
    chk("per_done_e16", done, 1);
    step(7);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_cmpl_done", done, 0);
    chk("stop_cmpl_busy", busy, 0);
    chk("stop_cmpl_count", count, 0);
    go(8'd3, 1'b0);
    step(5);
    chk("pz_count_e5", count, 1);
    pause = 1'b1;
    step(6);
    pause = 1'b0;
    chk("pz_count_e11", count, 1);
    chk("pz_busy_e11", busy, 1);
    step(1);
    chk("pz_done_e12", done, 0);
    chk("pz_count_e12", count, 1);
    step(5);
    chk("pz_count_e17", count, 2);
    chk("pz_done_e17", done, 0);
    step(1);
    chk("pz_done_e18", done, 1);
    chk("pz_count_e18", count, 3);
    chk("pz_exp_e18", expirado, 1);
    pause = 1'b1;
    step(2);
    pause = 1'b0;
    chk("pz_ign_busy", busy, 0);
    chk("pz_ign_exp", expirado, 1);
    go(8'd3, 1'b0);
    step(5);
    rst = 1'b1;
    step(1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_exp", expirado, 0);
    step(2);
    rst = 1'b0;
    step(5);
    chk("rst_idle_count", count, 0);
    chk("rst_idle_busy", busy, 0);
    go(8'd5, 1'b0);
    step(6);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_count", count, 0);
    chk("stop_busy", busy, 0);
    step(20);
    chk("stop_no_done", done, 0);
    chk("stop_no_exp", expirado, 0);
    go(8'd5, 1'b0);
    step(5);
    chk("rs_count_e5", count, 1);
    periodo = 8'd5;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("rs_count_e6", count, 0);
    chk("rs_busy_e6", busy, 1);
    step(19);
    chk("rs_done_e25", done, 0);
    chk("rs_count_e25", count, 4);
    step(1);
    chk("rs_done_e26", done, 1);
    chk("rs_count_e26", count, 5);
    chk("rs_exp_e26", expirado, 1);
    pause = 1'b1;
    go(8'd3, 1'b0);
    chk("sp_busy_e0", busy, 1);
    step(1);
    pause = 1'b0;
    step(3);
    chk("sp_count_e4", count, 0);
    step(1);
    chk("sp_count_e5", count, 1);
    go(8'd0, 1'b0);
    chk("z_os_done", done, 1);
    chk("z_os_exp", expirado, 1);
    chk("z_os_count", count, 0);
    chk("z_os_busy", busy, 0);
    step(1);
    chk("z_os_done_once", done, 0);
    chk("z_os_exp_hold", expirado, 1);
    go(8'd0, 1'b1);
    chk("z_per_done", done, 1);
    chk("z_per_busy", busy, 0);
    chk("z_per_exp", expirado, 0);
    step(1);
    chk("z_per_done_once", done, 0);
    periodo = 8'd1;
    periodico = 1'b0;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    chk("d1_busy_e0", busy_b, 1);
    chk("d1_done_e0", done_b, 0);
    step(1);
    chk("d1_done_e1", done_b, 1);
    chk("d1_count_e1", count_b, 1);
    chk("d1_exp_e1", expirado_b, 1);
    chk("d1_busy_e1", busy_b, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
